// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM encoding, reset vector
// default and the redirect-priority select used to pick the next pc.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD     = 3'd0,
        SEL_SEQ      = 3'd1,
        SEL_TRAP     = 3'd2,
        SEL_MRET     = 3'd3,
        SEL_BRANCH   = 3'd4,
        SEL_MISALIGN = 3'd5
    } pc_sel_e;

    // Fixed priority: trap > mret > branch > sequential advance > hold.
    function automatic pc_sel_e redirect_sel(
        input logic       trap,
        input logic       mret,
        input logic       br_taken,
        input logic [1:0] br_lsb,
        input logic       advance
    );
        pc_sel_e sel;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (mret) begin
            sel = SEL_MRET;
        end else if (br_taken) begin
            sel = (br_lsb == 2'b00) ? SEL_BRANCH : SEL_MISALIGN;
        end else if (advance) begin
            sel = SEL_SEQ;
        end else begin
            sel = SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_pc4.sv
// Sequential-fetch incrementer: pc + 4, wrapping modulo 2^32.
module pc_sequencer_pc4 (
    input  logic [31:0] pc_i,
    output logic [31:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: boot, sequential advance with handshake and
// stall, prioritised trap/mret/branch redirects with a one-cycle flush bubble.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        misalign,
    output logic [31:0] bad_addr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_plus4;
    pc_sel_e     sel;

    pc_sequencer_pc4 u_pc4 (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_plus4)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        sel        = redirect_sel(trap, mret, br_taken, br_target[1:0],
                                  fetch_ready && !stall);

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VEC;
            end
            ST_RUN: begin
                case (sel)
                    SEL_SEQ:    pc_d = pc_plus4;
                    SEL_TRAP:   pc_d = mtvec;
                    SEL_MRET:   pc_d = mepc;
                    SEL_BRANCH: pc_d = br_target;
                    SEL_MISALIGN: begin
                        // Misaligned target is converted into a trap to mtvec.
                        pc_d       = mtvec;
                        misalign_d = 1'b1;
                        bad_addr_d = br_target;
                    end
                    default:    pc_d = pc_q;
                endcase
                if (sel != SEL_HOLD && sel != SEL_SEQ) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            bad_addr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign misalign    = misalign_q;
    assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural fetch model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap = 1'b0;
    logic [31:0] mtvec = '0;
    logic        mret = 1'b0;
    logic [31:0] mepc = '0;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        misalign;
    logic [31:0] bad_addr;

    int checks = 0;
    int passed = 0;

    // Behavioural model: fetching or not, plus the architectural outputs.
    logic [31:0] m_pc;
    logic        m_fetching;
    logic        m_mis;
    logic [31:0] m_bad;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap        (trap),
        .mtvec       (mtvec),
        .mret        (mret),
        .mepc        (mepc),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .misalign    (misalign),
        .bad_addr    (bad_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Rules: reset wins; a non-fetching cycle (boot or flush bubble) holds pc
    // and resumes fetching; a fetching cycle takes the highest redirect or
    // advances by 4 when accepted and not stalled.
    task automatic model_edge();
        if (rst) begin
            m_pc = 32'h0; m_fetching = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
        end else if (!m_fetching) begin
            m_fetching = 1'b1; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (trap) begin
                m_pc = mtvec; m_fetching = 1'b0;
            end else if (mret) begin
                m_pc = mepc; m_fetching = 1'b0;
            end else if (br_taken) begin
                m_fetching = 1'b0;
                if (br_target % 4 == 0) m_pc = br_target;
                else begin m_pc = mtvec; m_mis = 1'b1; m_bad = br_target; end
            end else if (fetch_ready && !stall) begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_pc", pc, m_pc);
        check("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fetching});
        check("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
        check("model_bad_addr", bad_addr, m_bad);
    endtask

    task automatic clear_req();
        trap = 1'b0; mret = 1'b0; br_taken = 1'b0; stall = 1'b0;
    endtask

    initial begin
        m_pc = '0; m_fetching = 1'b0; m_mis = 1'b0; m_bad = '0;

        // Reset and boot sequence: 0 (boot), 0, 4, 8.
        rst = 1'b1; trap = 1'b0; tick();
        check("reset_pc", pc, 32'h0);
        check("reset_fv", {31'b0, fetch_valid}, 32'h0);
        check("reset_mis", {31'b0, misalign}, 32'h0);
        check("reset_bad", bad_addr, 32'h0);
        rst = 1'b0; fetch_ready = 1'b1; tick();
        check("boot_pc", pc, 32'h0);
        check("boot_fv_after", {31'b0, fetch_valid}, 32'h1);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);

        // Wrap at top of address space.
        br_taken = 1'b1; br_target = 32'hffff_fff8; tick();
        check("br_fv_bubble", {31'b0, fetch_valid}, 32'h0);
        clear_req(); tick(); check("br_pc", pc, 32'hffff_fff8);
        tick(); check("wrap_fffc", pc, 32'hffff_fffc);
        tick(); check("wrap_zero", pc, 32'h0);

        // All three redirects at once: trap wins.
        trap = 1'b1; mret = 1'b1; br_taken = 1'b1;
        mtvec = 32'h100; mepc = 32'h200; br_target = 32'h300; tick();
        check("prio_pc", pc, 32'h100);
        check("prio_fv", {31'b0, fetch_valid}, 32'h0);
        clear_req(); tick();
        check("prio_fv_back", {31'b0, fetch_valid}, 32'h1);
        tick(); check("prio_pc104", pc, 32'h104);

        // Misaligned branch target.
        br_taken = 1'b1; br_target = 32'h202; tick();
        check("mis_pc", pc, 32'h100);
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        check("mis_bad", bad_addr, 32'h202);
        clear_req(); tick();
        check("mis_drop", {31'b0, misalign}, 32'h0);
        check("mis_bad_hold", bad_addr, 32'h202);

        // Stall and not-ready hold at 0x40, then branch during stall.
        br_taken = 1'b1; br_target = 32'h40; tick();
        clear_req(); tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_pc", pc, 32'h40);
            check("stall_fv", {31'b0, fetch_valid}, 32'h1);
        end
        stall = 1'b0; fetch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("notready_pc", pc, 32'h40);
        end
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h80; tick();
        check("stall_br_pc", pc, 32'h80);
        clear_req(); fetch_ready = 1'b1; tick(); tick();

        // Reset together with a trap.
        rst = 1'b1; trap = 1'b1; mtvec = 32'h100; tick();
        check("rst_trap_pc", pc, 32'h0);
        check("rst_trap_fv", {31'b0, fetch_valid}, 32'h0);
        check("rst_trap_mis", {31'b0, misalign}, 32'h0);
        check("rst_trap_bad", bad_addr, 32'h0);
        rst = 1'b0; clear_req();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            trap        = ($urandom_range(0, 15) == 0);
            mret        = ($urandom_range(0, 15) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            br_target   = {$urandom(), 2'b00} | (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'h0);
            mtvec       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            mepc        = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold pc; no advance.
REQ-005 br_taken  input  1  branch/jump redirect request.
REQ-006 br_target  input  32  branch/jump destination.
REQ-007 trap  input  1  exception/interrupt redirect request.
REQ-008 mtvec  input  32  trap vector (word-aligned by CSR file).
REQ-009 mret  input  1  return-from-trap request.
REQ-010 mepc  input  32  return address.
REQ-011 fetch_ready  input  1  instruction memory accepts current pc.
REQ-012 pc  output  32  current fetch address.
REQ-013 fetch_valid  output  1  pc is a valid fetch request.
REQ-014 misalign  output  1  one-cycle pulse: misaligned branch target trapped.
REQ-015 bad_addr  output  32  offending target, latched with misalign.

Function
REQ-016 FSM states: BOOT, RUN, FLUSH. Encoding from the shared package.
REQ-017 BOOT: fetch_valid=0, pc=RESET_VEC; always go to RUN on the next cycle.
REQ-018 RUN: fetch_valid=1; sequential advance pc <= pc+4 only when fetch_ready=1 and stall=0.
REQ-019 pc+4 is modulo 2^32: 32'hffff_fffc advances to 32'h0000_0000; no flag is raised.
REQ-020 RUN, fetch_ready=0 or stall=1, no redirect: pc and state hold.
REQ-021 Redirect priority in RUN: trap > mret > br_taken > sequential; lower requests are ignored in the same cycle.
REQ-022 Redirects are taken regardless of stall or fetch_ready.
REQ-023 trap: pc <= mtvec; state -> FLUSH.
REQ-024 mret: pc <= mepc; state -> FLUSH.
REQ-025 br_taken with br_target[1:0]==0: pc <= br_target; state -> FLUSH.
REQ-026 br_taken with br_target[1:0]!=0: pc <= mtvec, misalign=1 and bad_addr <= br_target for exactly the next cycle; state -> FLUSH.
REQ-027 FLUSH: fetch_valid=0 for exactly one cycle; pc holds; redirect requests in FLUSH are ignored; state -> RUN.
REQ-028 Redirect latency: the new pc is visible on the cycle after the request; fetch_valid reasserts one cycle later.
REQ-029 BOOT ignores all redirect, stall and handshake inputs.
REQ-030 bad_addr holds its value until the next misaligned redirect.

Reset
REQ-031 rst=1 on a clock edge: state <= BOOT, pc <= RESET_VEC, fetch_valid=0, misalign=0, bad_addr <= 0.
REQ-032 rst has priority over every other input, including a redirect in the same cycle.
REQ-033 Reset mid-FLUSH or mid-RUN: the pending pc is discarded and BOOT is re-entered.

Structure
REQ-034 Shared package holds the FSM state typedef/encoding, RESET_VEC default and the redirect-priority select constants.
REQ-035 The increment uses the existing pc4 adder as the single sub-module instance; no other sub-modules.
REQ-036 pc, state, misalign and bad_addr are registers; fetch_valid decodes from state.

Verification
REQ-037 Reset, release, fetch_ready=1 for 3 cycles -> pc 0, 0 (BOOT), 4, 8; fetch_valid 0 then 1.
REQ-038 pc=32'hffff_fff8, fetch_ready=1 -> pc 32'hffff_fffc, then 32'h0000_0000.
REQ-039 trap=1, mret=1 and br_taken=1 together, mtvec=32'h100 -> pc 32'h100, one fetch_valid=0 cycle, then pc 32'h104.
REQ-040 br_taken=1, br_target=32'h202 -> pc=mtvec, misalign=1 for one cycle, bad_addr=32'h202.
REQ-041 stall=1 or fetch_ready=0 for 4 cycles at pc=32'h40 -> pc stays 32'h40, fetch_valid=1; br_taken to 32'h80 during stall -> pc 32'h80.
REQ-042 rst=1 in same cycle as trap -> pc=RESET_VEC, state BOOT, misalign=0.
